// File: rtl/ccg_eval_pipe.sv
// Pipelined, multi-lane evaluator of the 7-input/4-output CCG benchmark function
// with valid/ready flow control, a 32-bit output MISR and an accepted-beat counter.
module ccg_eval_pipe #(
    parameter int LANES = 4,
    parameter int PIPE  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   out_data,
    input  logic                 sig_clr,
    output logic [31:0]          sig,
    output logic [15:0]          cnt
);

    localparam int          DW        = 4 * LANES;
    localparam int          NCH       = (DW + 31) / 32;
    localparam logic [31:0] MISR_POLY = 32'h0040_0007;

    function automatic logic [3:0] eval_lane(input logic [6:0] x);
        logic a, b, p, f1, f2, f3, f4;
        a  = ~(x[0] ^ x[3]);
        b  = ~((~x[2] & ~x[6]) ^ (~x[1] & ~x[4]));
        p  = x[5] & a & b;
        f3 = x[5] & ((~x[0] & ~x[2]) | (~x[0] & x[4]) | x[1] | x[6]);
        f1 = p & ~f3;
        f2 = p | (~x[5] & (x[3] | x[6]));
        f4 = ~(x[1] & x[3]);
        return {f4, f3, f2, f1};
    endfunction

    // XOR of the 32-bit chunks of a beat, zero-padded at the top
    function automatic logic [31:0] fold32(input logic [DW-1:0] d);
        logic [NCH*32-1:0] pad;
        logic [31:0]       f;
        pad         = '0;
        pad[DW-1:0] = d;
        f           = 32'h0000_0000;
        for (int c = 0; c < NCH; c++) begin
            f = f ^ pad[32*c +: 32];
        end
        return f;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [DW-1:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0000_0000) ^ fold32(d);
    endfunction

    logic [DW-1:0]   lane_res_s;
    logic [PIPE-1:0] ready_s;
    logic [PIPE-1:0] v_q, v_d;
    logic [DW-1:0]   data_q [PIPE];
    logic [DW-1:0]   data_d [PIPE];
    logic [31:0]     sig_q, sig_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            out_hs_s;

    // Per-lane function on the stage-0 inputs
    always_comb begin
        lane_res_s = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_res_s[4*k +: 4] = eval_lane(in_data[7*k +: 7]);
        end
    end

    // Stage i may load when any stage from i to the output has room or the sink drains
    always_comb begin
        logic acc;
        acc     = out_ready;
        ready_s = '0;
        for (int i = PIPE - 1; i >= 0; i--) begin
            acc        = acc | ~v_q[i];
            ready_s[i] = acc;
        end
    end

    // Stage next-state: a loading stage takes its upstream, data only moves with a valid beat
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (ready_s[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = lane_res_s;
            end else begin
                data_d[0] = data_q[0];
            end
        end else begin
            v_d[0] = v_q[0];
        end
        for (int i = 1; i < PIPE; i++) begin
            if (ready_s[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end else begin
                    data_d[i] = data_q[i];
                end
            end else begin
                v_d[i] = v_q[i];
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign out_hs_s = v_q[PIPE-1] & out_ready;

    // Signature and counter next-state; clear wins over a same-cycle handshake
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (sig_clr) begin
            sig_d = 32'h0000_0000;
            cnt_d = 16'h0000;
        end else if (out_hs_s) begin
            sig_d = misr_step(sig_q, data_q[PIPE-1]);
            cnt_d = cnt_q + 16'd1;
        end else begin
            sig_d = sig_q;
            cnt_d = cnt_q;
        end
    end

    // Signature and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 32'h0000_0000;
            cnt_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = ready_s[0];
    assign out_valid = v_q[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign sig       = sig_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_ccg_eval_pipe.sv
// Randomised self-checking bench for ccg_eval_pipe with a scoreboard and
// behavioural model of the lane function, MISR and beat counter.
module tb_ccg_eval_pipe;

    localparam int LANES = 4;
    localparam int PIPE  = 2;
    localparam int DW    = 4 * LANES;
    localparam int IW    = 7 * LANES;

    logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, sig_clr;
    logic [IW-1:0] in_data;
    logic [DW-1:0] out_data;
    logic [31:0]   sig;
    logic [15:0]   cnt;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   m_sig;
    logic [15:0]   m_cnt;
    int            out_hs_total = 0;
    logic          rdy_rand;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    ccg_eval_pipe #(.LANES(LANES), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sig_clr   (sig_clr),
        .sig       (sig),
        .cnt       (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_lane(input int code);
        bit x0, x1, x2, x3, x4, x5, x6, a, b, p, f1, f2, f3, f4;
        x0 = ((code >> 0) & 1) != 0;
        x1 = ((code >> 1) & 1) != 0;
        x2 = ((code >> 2) & 1) != 0;
        x3 = ((code >> 3) & 1) != 0;
        x4 = ((code >> 4) & 1) != 0;
        x5 = ((code >> 5) & 1) != 0;
        x6 = ((code >> 6) & 1) != 0;
        a  = (x0 == x3);
        b  = ((!x2 && !x6) == (!x1 && !x4));
        p  = x5 && a && b;
        f3 = x5 && ((!x0 && !x2) || (!x0 && x4) || x1 || x6);
        f1 = p && !f3;
        f2 = p || (!x5 && (x3 || x6));
        f4 = !(x1 && x3);
        return {f4, f3, f2, f1};
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [IW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[4*k +: 4] = ref_lane(int'(d[7*k +: 7]));
        return r;
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [DW-1:0] d);
        logic [255:0] pad;
        logic [31:0]  f;
        pad = '0;
        pad[DW-1:0] = d;
        f = 32'd0;
        for (int c = 0; c < (DW + 31) / 32; c++) f = f ^ pad[32*c +: 32];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ f;
    endfunction

    function automatic logic [IW-1:0] rand_in();
        logic [IW-1:0] d;
        for (int k = 0; k < LANES; k++) d[7*k +: 7] = 7'($urandom_range(0, 127));
        return d;
    endfunction

    // Scoreboard and signature model, evaluated on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_sig = 32'd0;
                m_cnt = 16'd0;
                prev_stall = 1'b0;
            end else begin
                check_eq("sig_model", sig, m_sig);
                check_eq("cnt_model", cnt, m_cnt);
                if (prev_stall) begin
                    check_eq("hold_valid", out_valid, 1'b1);
                    check_eq("hold_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("spurious_beat", out_valid, 1'b0);
                    else check_eq("beat", out_data, exp_q.pop_front());
                    out_hs_total++;
                    if (!sig_clr) begin
                        m_sig = ref_misr(m_sig, out_data);
                        m_cnt = m_cnt + 16'd1;
                    end
                end
                if (sig_clr) begin
                    m_sig = 32'd0;
                    m_cnt = 16'd0;
                end
                if (in_valid && in_ready) exp_q.push_back(ref_beat(in_data));
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [IW-1:0] d);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check_eq("send_accept", got, 1'b1);
    endtask

    task automatic wait_out();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_eq("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [IW-1:0] d;
        logic [DW-1:0] held;
        logic [6:0]    codes [3];
        logic [3:0]    nibs  [3];
        int            n, base;
        codes = '{7'h7F, 7'h20, 7'h29};
        nibs  = '{4'h6, 4'hE, 4'hB};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        sig_clr = 1'b0; rdy_rand = 1'b0;
        #3;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_sig", sig, 0);
        check_eq("rst_cnt", cnt, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);

        // All-zero operands, latency PIPE
        tick();
        out_ready = 1'b1;
        send_beat('0);
        @(negedge clk);
        check_eq("lat_t1_valid", out_valid, 1'b0);
        @(negedge clk);
        check_eq("lat_t2_valid", out_valid, 1'b1);
        check_eq("zero_data", out_data, 16'h8888);
        @(negedge clk);
        check_eq("zero_sig", sig, 32'h0000_8888);
        check_eq("zero_cnt", cnt, 16'd1);
        tick();

        // Directed single-lane codes
        for (int i = 0; i < 3; i++) begin
            d = '0;
            d[6:0] = codes[i];
            send_beat(d);
            wait_out();
            check_eq($sformatf("code_%0h", codes[i]), out_data[3:0], nibs[i]);
            tick();
        end

        // Exhaustive per-lane sweep with random backpressure
        sig_clr = 1'b1;
        tick();
        sig_clr = 1'b0;
        rdy_rand = 1'b1;
        for (int c = 0; c < 128; c++) begin
            for (int k = 0; k < LANES; k++) d[7*k +: 7] = 7'((c + 37 * k) % 128);
            if ($urandom_range(0, 3) == 0) tick();
            send_beat(d);
        end
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain();
        check_eq("sweep_cnt", cnt, 16'd128);
        tick();

        // Full pipeline stall, stable output, refill and drain rate
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < PIPE + 3; i++) begin
            in_data = rand_in();
            tick();
        end
        @(negedge clk);
        check_eq("bp_in_ready", in_ready, 1'b0);
        check_eq("bp_depth", exp_q.size(), PIPE);
        check_eq("bp_out_valid", out_valid, 1'b1);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            in_data = rand_in();
            @(negedge clk);
            check_eq("bp_stable", out_data, held);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_refill_ready", in_ready, 1'b1);
        check_eq("bp_refill_valid", out_valid, 1'b1);
        tick();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) n++;
            else break;
        end
        check_eq("drain_rate", n, PIPE);
        tick();

        // Reset with beats in flight
        out_ready = 1'b0;
        send_beat(rand_in());
        send_beat(rand_in());
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_sig", sig, 0);
        check_eq("mid_rst_cnt", cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("no_stale", out_valid, 1'b0);
        end
        tick();

        // Clear coincident with an output handshake
        for (int i = 0; i < 3; i++) send_beat(rand_in());
        drain();
        check_eq("pre_clr_cnt", cnt, 16'd3);
        tick();
        out_ready = 1'b0;
        send_beat(rand_in());
        wait_out();
        tick();
        sig_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("clr_beat_valid", out_valid, 1'b1);
        tick();
        sig_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_sig", sig, 0);
        check_eq("clr_cnt", cnt, 0);
        tick();

        // Counter wrap after 65536 handshakes
        sig_clr = 1'b1;
        tick();
        sig_clr = 1'b0;
        base = out_hs_total;
        in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_data = rand_in();
            tick();
            if (out_hs_total - base >= 65536) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("wrap_hs", out_hs_total - base, 65536);
        check_eq("wrap_cnt", cnt, 16'd0);
        tick();
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
